sw_pe_affine_gen: RTL
=====================

// Module: sw_pe_affine_gen
// PURPOSE
//  Next-generation Smith-Waterman/Needleman-Wunsch systolic processing element: one query symbol per PE,
//  target symbols streamed left->right. Affine-gap scoring, width-generic symbols, local/global mode,
//  saturating biased arithmetic, and high-score column tracking. PEs chain by abutment to form the array.
// PARAMETERS
//  SCORE_WIDTH  12  score width; biased representation, ZERO = 2**(SCORE_WIDTH-1)
//  SYM_WIDTH    2   symbol width (2 = DNA A/G/T/C, 5 = protein)
//  COL_WIDTH    10  target column counter width (max target length 2**COL_WIDTH-1)
//  PE_IDX       0   row index of this PE in the array (1-based row = PE_IDX+1)
//  GLOBAL       0   0 = local (Smith-Waterman), 1 = global (Needleman-Wunsch)
// PORTS
//  clk           in   1            clock
//  rst           in   1            synchronous reset, active low
//  query_ld      in   1            load query symbol (honoured only when idle)
//  query_in      in   SYM_WIDTH    query symbol for this row
//  en_in         in   1            target stream valid from left neighbour
//  data_in       in   SYM_WIDTH    target symbol
//  M_in / I_in   in   SCORE_WIDTH  left-neighbour M / I scores
//  High_in       in   SCORE_WIDTH  left-neighbour running high score
//  High_pos_in   in   COL_WIDTH    column of High_in
//  match, mismatch, gap_open, gap_extend  in SCORE_WIDTH  two's-complement penalties, held static
//  data_out      out  SYM_WIDTH    target symbol to right neighbour
//  M_out / I_out out  SCORE_WIDTH  current-column M / I scores
//  High_out      out  SCORE_WIDTH  running high score
//  High_pos_out  out  COL_WIDTH    column (1-based) of High_out
//  en_out        out  1            en_in delayed one cycle
//  vld           out  1            one-cycle pulse: High_out/High_pos_out final
// BEHAVIOUR
//  Reset (rst=0 at edge): M_out=I_out=High_out=ZERO, High_pos_out=0, data_out=0, en_out=0, vld=0,
//   query=0, states idle. Reset mid-stream aborts the sequence; no vld.
//  Score stage FSM {SC_IDLE, SC_CALC}: IDLE->CALC on en_in=1; CALC->IDLE on en_in=0. Each en_in=1 cycle:
//   S = (data_in==query)? match : mismatch; M = S + max(M_diag, I_diag);
//   I = max(max(M_in,M_out)+gap_open+gap_extend, max(I_in,I_out)+gap_extend);
//   M_diag<=M_in, I_diag<=I_in, data_out<=data_in; latency 1 cycle.
//  First column (IDLE with en_in=1): diag/up = boundary B(r). Local: B=ZERO.
//   Global: B(0)=ZERO, B(k)=ZERO+gap_open+k*gap_extend. Diag uses B(PE_IDX), up uses B(PE_IDX+1).
//   B values are registered at query_ld (constant multiply by PE_IDX).
//  Local mode: M clamped to >= ZERO. Global mode: no clamp.
//  All adds saturate to [0, 2**SCORE_WIDTH-1]; never wrap.
//  Column counter: resets to 1 at the first en_in; increments per valid cycle; saturates at all-ones.
//  High stage FSM {HS_IDLE, HS_CALC}, driven by en_out, one cycle after the score stage:
//   cand=max(M_out,I_out). Replace when cand > max(High_in, High_out); ties keep the earlier column.
//   High_pos follows the selected source. In HS_IDLE, the first compare is against High_in only.
//  vld=1 for exactly one cycle, the cycle after en_out falls.
//  Next sequence: en_in may re-rise the cycle after it falls; the vld of the old sequence still pulses.
//   Counter and High restart cleanly.
//  en_in held low in idle: M_out/I_out/High_out forced to ZERO.
//  query_ld while en_in or en_out is high is ignored.
// CONFIGURATION
//  SW_PE_TRACEBACK_EN defined: extra output tb_out[2:0], registered with M_out:
//   [0] = M source (1 = I_diag), [1] = I source (1 = extend), [2] = new high this column.
//  Not defined: no port, no logic.
// STRUCTURE
//  Package sw_pkg: nucleotide codes A=0, G=1, T=2, C=3; sc_/hs_ state encodings; sat_add and
//   bias-ZERO functions.
//  Sub-module sw_pe_high_tracker: the high-score stage (FSM, compare, position, vld).
// TESTING (match=2, mismatch=-1, gap_open=-2, gap_extend=-1, SCORE_WIDTH=12, ZERO=2048)
//  1 Local PE0, query A, target A,G,A, left inputs ZERO -> M_out 2050, 2048, 2050;
//    High_out=2050, High_pos=1; vld 2 cycles after en_in falls.
//  2 Global PE_IDX=1, query A, target G -> diag B(1)=2045, M_out=2044 (no clamp).
//  3 Saturation: M_in=I_in=4094, match=5 -> M_out=4095, no wrap.
//  4 Back-to-back: en_in low for 1 cycle between 2 targets -> two vld pulses; second High is independent.
//  5 rst=0 mid-stream -> all outputs at reset values next edge; no vld.
//  6 With SW_PE_TRACEBACK_EN, target A after I_diag > M_diag -> tb_out[0]=1.

Source files
------------

// File: rtl/sw_pkg.sv
// sw_pkg: shared symbol codes, stage state encodings and biased saturating score helpers
package sw_pkg;
  typedef enum logic [1:0] {NT_A, NT_G, NT_T, NT_C} nt_t;
  typedef enum logic {SC_IDLE, SC_CALC} sc_state_t;
  typedef enum logic {HS_IDLE, HS_CALC} hs_state_t;

  function automatic int bias_zero(input int w);
    return 1 << (w - 1);
  endfunction

  function automatic int sat_add(input int a, input int b, input int w);
    int s;
    int m;
    s = a + b;
    m = (1 << w) - 1;
    return s < 0 ? 0 : (s > m ? m : s);
  endfunction
endpackage

// File: rtl/sw_pe_high_tracker.sv
// sw_pe_high_tracker: running high score and column of one PE, with end-of-sequence vld pulse
module sw_pe_high_tracker
  import sw_pkg::*;
#(
  parameter int SCORE_WIDTH = 12,
  parameter int COL_WIDTH   = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [SCORE_WIDTH-1:0] m,
  input  logic [SCORE_WIDTH-1:0] i,
  input  logic [COL_WIDTH-1:0]   col,
  input  logic [SCORE_WIDTH-1:0] high_in,
  input  logic [COL_WIDTH-1:0]   high_pos_in,
  output logic [SCORE_WIDTH-1:0] high_out,
  output logic [COL_WIDTH-1:0]   high_pos_out,
  output logic                   vld
);
  localparam logic [SCORE_WIDTH-1:0] ZERO = SCORE_WIDTH'(bias_zero(SCORE_WIDTH));

  hs_state_t              hs_state, hs_next;
  logic [SCORE_WIDTH-1:0] cand, best;
  logic [COL_WIDTH-1:0]   best_pos;
  logic                   take_in, new_high;

  // pick the best of neighbour/own high; a new column wins only when strictly greater
  always_comb begin
    hs_next  = en ? HS_CALC : HS_IDLE;
    cand     = m > i ? m : i;
    take_in  = hs_state == HS_IDLE || high_in > high_out;
    best     = take_in ? high_in : high_out;
    best_pos = take_in ? high_pos_in : high_pos_out;
    new_high = cand > best;
  end

  // high register holds through the vld cycle, then returns to ZERO while idle
  always_ff @(posedge clk) begin
    if (!rst) begin
      hs_state     <= HS_IDLE;
      high_out     <= ZERO;
      high_pos_out <= '0;
      vld          <= 1'b0;
    end else begin
      hs_state <= hs_next;
      vld      <= hs_state == HS_CALC && !en;
      if (en) begin
        high_out     <= new_high ? cand : best;
        high_pos_out <= new_high ? col : best_pos;
      end else if (hs_state == HS_IDLE) begin
        high_out     <= ZERO;
        high_pos_out <= '0;
      end
    end
  end
endmodule

// File: rtl/sw_pe_affine_gen.sv
// sw_pe_affine_gen: affine-gap SW/NW systolic PE; optional tb_out traceback bits with SW_PE_TRACEBACK_EN
module sw_pe_affine_gen
  import sw_pkg::*;
#(
  parameter int SCORE_WIDTH = 12,
  parameter int SYM_WIDTH   = 2,
  parameter int COL_WIDTH   = 10,
  parameter int PE_IDX      = 0,
  parameter int GLOBAL      = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   query_ld,
  input  logic [SYM_WIDTH-1:0]   query_in,
  input  logic                   en_in,
  input  logic [SYM_WIDTH-1:0]   data_in,
  input  logic [SCORE_WIDTH-1:0] M_in,
  input  logic [SCORE_WIDTH-1:0] I_in,
  input  logic [SCORE_WIDTH-1:0] High_in,
  input  logic [COL_WIDTH-1:0]   High_pos_in,
  input  logic [SCORE_WIDTH-1:0] match,
  input  logic [SCORE_WIDTH-1:0] mismatch,
  input  logic [SCORE_WIDTH-1:0] gap_open,
  input  logic [SCORE_WIDTH-1:0] gap_extend,
  output logic [SYM_WIDTH-1:0]   data_out,
  output logic [SCORE_WIDTH-1:0] M_out,
  output logic [SCORE_WIDTH-1:0] I_out,
  output logic [SCORE_WIDTH-1:0] High_out,
  output logic [COL_WIDTH-1:0]   High_pos_out,
  output logic                   en_out,
  output logic                   vld
`ifdef SW_PE_TRACEBACK_EN
  ,
  output logic [2:0]             tb_out
`endif
);
  localparam int                     Z    = bias_zero(SCORE_WIDTH);
  localparam logic [SCORE_WIDTH-1:0] ZERO = SCORE_WIDTH'(Z);

  sc_state_t              sc_state, sc_next;
  logic [SYM_WIDTH-1:0]   query;
  logic [SCORE_WIDTH-1:0] b_diag, b_up, m_diag, i_diag;
  logic [SCORE_WIDTH-1:0] md, id, ml, il, up_m, up_i, m_new, i_new;
  logic [COL_WIDTH-1:0]   col;
  logic                   first, i_src, ext_src;
  int                     go, ge, s_pen, m_sum, open_t, ext_t, bd, bu;

  // one column of the recurrence; first column takes the row boundary in place of diag/left
  always_comb begin
    sc_next = en_in ? SC_CALC : SC_IDLE;
    first   = sc_state == SC_IDLE;
    go      = int'(signed'(gap_open));
    ge      = int'(signed'(gap_extend));
    bd      = GLOBAL == 0 || PE_IDX == 0 ? Z : sat_add(Z, go + PE_IDX * ge, SCORE_WIDTH);
    bu      = GLOBAL == 0 ? Z : sat_add(Z, go + (PE_IDX + 1) * ge, SCORE_WIDTH);
    md      = first ? b_diag : m_diag;
    id      = first ? b_diag : i_diag;
    ml      = first ? b_up : M_out;
    il      = first ? b_up : I_out;
    i_src   = id > md;
    s_pen   = data_in == query ? int'(signed'(match)) : int'(signed'(mismatch));
    m_sum   = sat_add(int'(i_src ? id : md), s_pen, SCORE_WIDTH);
    m_new   = GLOBAL == 0 && m_sum < Z ? ZERO : SCORE_WIDTH'(m_sum);
    up_m    = M_in > ml ? M_in : ml;
    up_i    = I_in > il ? I_in : il;
    open_t  = sat_add(int'(up_m), go + ge, SCORE_WIDTH);
    ext_t   = sat_add(int'(up_i), ge, SCORE_WIDTH);
    ext_src = ext_t > open_t;
    i_new   = SCORE_WIDTH'(ext_src ? ext_t : open_t);
  end

  // score stage: query/boundary load while fully idle, column update per valid target
  always_ff @(posedge clk) begin
    if (!rst) begin
      sc_state <= SC_IDLE;
      query    <= SYM_WIDTH'(NT_A);
      b_diag   <= ZERO;
      b_up     <= ZERO;
      m_diag   <= ZERO;
      i_diag   <= ZERO;
      M_out    <= ZERO;
      I_out    <= ZERO;
      data_out <= '0;
      en_out   <= 1'b0;
      col      <= '0;
    end else begin
      sc_state <= sc_next;
      en_out   <= en_in;
      if (query_ld && !en_in && !en_out) begin
        query  <= query_in;
        b_diag <= SCORE_WIDTH'(bd);
        b_up   <= SCORE_WIDTH'(bu);
      end
      if (en_in) begin
        m_diag   <= M_in;
        i_diag   <= I_in;
        data_out <= data_in;
        M_out    <= m_new;
        I_out    <= i_new;
        col      <= first ? COL_WIDTH'(1) : (&col ? col : col + COL_WIDTH'(1));
      end else begin
        M_out <= ZERO;
        I_out <= ZERO;
      end
    end
  end

  sw_pe_high_tracker #(
    .SCORE_WIDTH(SCORE_WIDTH),
    .COL_WIDTH  (COL_WIDTH)
  ) u_high (
    .clk         (clk),
    .rst         (rst),
    .en          (en_out),
    .m           (M_out),
    .i           (I_out),
    .col         (col),
    .high_in     (High_in),
    .high_pos_in (High_pos_in),
    .high_out    (High_out),
    .high_pos_out(High_pos_out),
    .vld         (vld)
  );

`ifdef SW_PE_TRACEBACK_EN
  logic [SCORE_WIDTH-1:0] best_c, cand_c;
  logic                   best_hit;
  assign cand_c   = m_new > i_new ? m_new : i_new;
  assign best_hit = first || cand_c > best_c;
  // traceback bits travel with M_out; bit 2 flags a new best among this PE's own columns
  always_ff @(posedge clk) begin
    if (!rst) begin
      tb_out <= '0;
      best_c <= ZERO;
    end else if (en_in) begin
      tb_out <= {best_hit, ext_src, i_src};
      best_c <= best_hit ? cand_c : best_c;
    end
  end
`endif
endmodule
